// File: rtl/i2c_slave_controller.sv
// rtl/i2c_slave_controller.sv - I2C slave protocol FSM sequenced by an external bit timer.
// Define I2C_GENERAL_CALL_EN to acknowledge the 8'h00 general-call address.
module i2c_slave_controller #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       ack_check,
  input  logic       ack_done,
  input  logic [7:0] rx_data,
  input  logic       sda_in,
  input  logic       tx_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic [1:0] sda_mode,
  output logic       load_data,
  output logic       read_enable,
  output logic       rx_write,
  output logic       busy,
  output logic       underrun,
  output logic       general_call
);

  typedef enum logic [3:0] {
    IDLE, ADDR, CHK_ADDR, ACK_ADDR, NACK_ADDR, RX, RX_ACK,
    LOAD, TX, TX_CHK, TX_DONE, IGNORE
  } state_t;

  state_t     state, next_state;
  logic [7:0] addr_byte, addr_next;
  logic       rw, rw_next;
  logic       mack, mack_next;
  logic       rx_write_next;
  logic [1:0] sda_mode_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_byte <= 8'h00;
      rw        <= 1'b0;
      mack      <= 1'b0;
    end else begin
      state     <= next_state;
      addr_byte <= addr_next;
      rw        <= rw_next;
      mack      <= mack_next;
    end
  end

  always_comb begin
    next_state    = state;
    addr_next     = addr_byte;
    rw_next       = rw;
    mack_next     = mack;
    rx_write_next = 1'b0;
    if (stop_found) begin
      next_state = IDLE;
    end else if (start_found) begin
      next_state = ADDR;
    end else begin
      case (state)
        // The address byte is captured so CHK_ADDR does not depend on byte_received still being high.
        ADDR: if (byte_received) begin
          next_state = CHK_ADDR;
          addr_next  = rx_data;
        end
        CHK_ADDR: begin
`ifdef I2C_GENERAL_CALL_EN
          if (addr_byte == 8'h00) begin
            next_state = ACK_ADDR;
            rw_next    = 1'b0;
          end else
`endif
          if (addr_byte[7:1] == SLAVE_ADDR) begin
            if (addr_byte[0] && tx_empty) begin
              next_state = NACK_ADDR;
            end else begin
              next_state = ACK_ADDR;
              rw_next    = addr_byte[0];
            end
          end else begin
            next_state = IGNORE;
          end
        end
        ACK_ADDR:  if (ack_done) next_state = rw ? LOAD : RX;
        NACK_ADDR: if (ack_done) next_state = IGNORE;
        RX: if (byte_received) begin
          next_state    = RX_ACK;
          rx_write_next = 1'b1;
        end
        RX_ACK: if (ack_done) next_state = RX;
        LOAD:   next_state = TX;
        TX:     if (ack_prep) next_state = TX_CHK;
        TX_CHK: if (ack_check) begin
          next_state = TX_DONE;
          mack_next  = sda_in;
        end
        TX_DONE: if (ack_done) next_state = mack ? IGNORE : LOAD;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    sda_mode_next = 2'b00;
    case (next_state)
      ACK_ADDR, RX_ACK: sda_mode_next = 2'b01;
      NACK_ADDR:        sda_mode_next = 2'b10;
      TX:               sda_mode_next = 2'b11;
      default:          sda_mode_next = 2'b00;
    endcase
  end

  // Outputs decode next_state so they line up with the state register in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_enable   <= 1'b0;
      tx_enable   <= 1'b0;
      sda_mode    <= 2'b00;
      load_data   <= 1'b0;
      read_enable <= 1'b0;
      rx_write    <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      rx_enable   <= (next_state == ADDR) || (next_state == RX);
      tx_enable   <= (next_state == TX);
      sda_mode    <= sda_mode_next;
      load_data   <= (next_state == LOAD);
      read_enable <= (next_state == LOAD);
      rx_write    <= rx_write_next;
      busy        <= (next_state != IDLE);
      if (start_found)
        underrun <= 1'b0;
      else if ((state == LOAD) && tx_empty)
        underrun <= 1'b1;
    end
  end

`ifdef I2C_GENERAL_CALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      general_call <= 1'b0;
    else if (stop_found || start_found)
      general_call <= 1'b0;
    else if ((state == CHK_ADDR) && (addr_byte == 8'h00))
      general_call <= 1'b1;
  end
`else
  assign general_call = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb/tb_i2c_slave_controller.sv - randomized self-checking bench for i2c_slave_controller.
module tb_i2c_slave_controller;

`ifdef I2C_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_found = 1'b0, stop_found = 1'b0;
  logic       byte_received = 1'b0, ack_prep = 1'b0, ack_check = 1'b0, ack_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       sda_in = 1'b1;
  logic       tx_empty;
  logic       rx_enable, tx_enable, load_data, read_enable, rx_write, busy, underrun, general_call;
  logic [1:0] sda_mode;
  logic [9:0] outs;

  always #5 clk = ~clk;

  i2c_slave_controller #(.SLAVE_ADDR(7'h3C)) dut (
    .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep), .ack_check(ack_check),
    .ack_done(ack_done), .rx_data(rx_data), .sda_in(sda_in), .tx_empty(tx_empty),
    .rx_enable(rx_enable), .tx_enable(tx_enable), .sda_mode(sda_mode),
    .load_data(load_data), .read_enable(read_enable), .rx_write(rx_write),
    .busy(busy), .underrun(underrun), .general_call(general_call)
  );

  assign outs = {rx_enable, tx_enable, sda_mode, load_data, read_enable, rx_write,
                 busy, underrun, general_call};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: logs pushed RX bytes, counts TX loads/pops and pulse-width violations.
  int         rx_cnt = 0, ld_cnt = 0, pops_seen = 0, pops_eff = 0, width_err = 0;
  int         tx_fill = 0, pops_base = 0;
  logic [7:0] rx_log [256];
  logic       prev_rxw = 1'b0, prev_re = 1'b0;

  assign tx_empty = ((pops_eff - pops_base) >= tx_fill);

  always @(negedge clk) begin
    pops_eff = pops_seen;
    if (read_enable) pops_seen++;
    if (load_data) ld_cnt++;
    if (rx_write) begin
      rx_log[rx_cnt % 256] = rx_data;
      rx_cnt++;
    end
    if ((rx_write && prev_rxw) || (read_enable && prev_re)) width_err++;
    prev_rxw = rx_write;
    prev_re  = read_enable;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_found = 1'b1; cyc(1); start_found = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_found = 1'b1; cyc(1); stop_found = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; byte_received = 1'b1; cyc(3); byte_received = 1'b0;
  endtask

  task automatic pulse_ack_done();
    ack_done = 1'b1; cyc(1); ack_done = 1'b0;
  endtask

  logic [7:0] tdata [4];

  // kind: 0 ignore, 1 nack, 2 acked write, 3 acked read (master ACKs all but the last byte)
  task automatic run_txn(input logic [7:0] ab, input int nb, input int fill);
    int   kind, rxb, ldb;
    logic gc_exp;
    gc_exp = GC_EN && (ab == 8'h00);
    if (gc_exp) kind = 2;
    else if (ab[7:1] == 7'h3C) kind = ab[0] ? ((fill == 0) ? 1 : 3) : 2;
    else kind = 0;
    pops_base = pops_eff; tx_fill = fill; rxb = rx_cnt; ldb = ld_cnt;
    pulse_start();
    check("start_underrun_clr", underrun, 0);
    check("addr_rx_en", rx_enable, 1);
    send_byte(ab);
    check("addr_ack_sda", sda_mode, (kind == 0) ? 0 : (kind == 1) ? 2 : 1);
    check("gc_flag", general_call, gc_exp);
    pulse_ack_done();
    if (kind == 2) begin
      for (int i = 0; i < nb; i++) begin
        cyc(2);
        check("rx_state", {rx_enable, sda_mode}, 3'b100);
        send_byte(tdata[i]);
        check("rx_ack_sda", sda_mode, 1);
        pulse_ack_done();
      end
    end else if (kind == 3) begin
      for (int i = 0; i < nb; i++) begin
        cyc(2);
        check("tx_state", {tx_enable, sda_mode}, 3'b111);
        ack_prep = 1'b1; cyc(1); ack_prep = 1'b0;
        cyc(1);
        check("tx_chk_sda", sda_mode, 0);
        sda_in = (i == nb - 1);
        ack_check = 1'b1; cyc(2); ack_check = 1'b0;
        pulse_ack_done();
        sda_in = 1'b1;
      end
    end else begin
      cyc(2);
      check("ign_idle", {rx_enable, tx_enable, sda_mode}, 0);
      send_byte(8'($urandom));
      check("ign_sda", sda_mode, 0);
      pulse_ack_done();
    end
    cyc(2);
    check("rx_writes", rx_cnt - rxb, (kind == 2) ? nb : 0);
    if (kind == 2)
      for (int i = 0; i < nb; i++) check("rx_byte", rx_log[(rxb + i) % 256], tdata[i]);
    check("loads", ld_cnt - ldb, (kind == 3) ? nb : 0);
    check("underrun", underrun, (kind == 3) && (nb > fill));
    check("busy_in_txn", busy, 1);
    pulse_stop();
    cyc(1);
    check("stop_idle", {busy, general_call}, 0);
  endtask

  task automatic rep_start_mid_rx();
    int rxb;
    pops_base = pops_eff; tx_fill = 0; rxb = rx_cnt;
    pulse_start();
    send_byte(8'h78);
    pulse_ack_done();
    cyc(2);
    check("rs_in_rx", {rx_enable, sda_mode}, 3'b100);
    rx_data = 8'hEE;
    pulse_start();
    tx_fill = 1;
    send_byte(8'h79);
    check("rs_readdr_ack", sda_mode, 1);
    pulse_ack_done();
    cyc(2);
    check("rs_now_tx", tx_enable, 1);
    check("rs_no_write", rx_cnt - rxb, 0);
    pulse_stop();
    cyc(1);
  endtask

  task automatic reset_mid_tx();
    pops_base = pops_eff; tx_fill = 2;
    pulse_start();
    send_byte(8'h79);
    pulse_ack_done();
    cyc(3);
    check("tx_before_rst", {tx_enable, sda_mode}, 3'b111);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", outs, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    check("post_rst_idle", outs, 0);
  endtask

  initial begin
    logic [6:0] a;
    rst = 1'b1;
    cyc(2);
    check("reset_outs", outs, 0);
    rst = 1'b0;
    cyc(2);
    check("idle_outs", outs, 0);

    tdata[0] = 8'hA5; tdata[1] = 8'h5A;
    run_txn(8'h78, 2, 0);
    run_txn(8'h79, 2, 2);
    run_txn(8'h79, 1, 0);
    run_txn(8'hA0, 1, 0);
    run_txn(8'h79, 2, 1);
    run_txn(8'h00, 1, 0);
    rep_start_mid_rx();
    reset_mid_tx();

    for (int t = 0; t < 30; t++) begin
      int sel;
      sel = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) tdata[i] = 8'($urandom);
      if (sel <= 1) begin
        run_txn({7'h3C, 1'($urandom)}, $urandom_range(1, 3), $urandom_range(0, 3));
      end else if (sel == 2) begin
        run_txn(8'h00, $urandom_range(1, 3), 0);
      end else begin
        do a = 7'($urandom_range(0, 127)); while (a == 7'h3C || a == 7'h00);
        run_txn({a, 1'($urandom)}, 1, $urandom_range(0, 3));
      end
    end

    check("pulse_width", width_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1);
  end

endmodule
